// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control unit: sequences fetch/decode/execute/memory/writeback
// with imem, dmem and optional MDU handshakes, retire counting and illegal-instruction trap.
module multicycle_control_unit #(
  parameter int M_EXT     = 0,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [6:0]           opcode,
  input  logic [2:0]           funct3,
  input  logic [6:0]           funct7,
  input  logic                 imem_ready,
  input  logic                 dm_ready,
  input  logic                 mdu_done,
  output logic                 imem_req,
  output logic                 ir_write,
  output logic                 ru_write,
  output logic [3:0]           alu_op,
  output logic [2:0]           imm_src,
  output logic [1:0]           alu_a_src,
  output logic                 alu_b_src,
  output logic                 dm_req,
  output logic                 dm_write,
  output logic [2:0]           dm_ctrl,
  output logic [4:0]           br_op,
  output logic [1:0]           ru_data_src,
  output logic                 pc_write,
  output logic                 mdu_start,
  output logic                 retire,
  output logic [CNT_WIDTH-1:0] instret,
  output logic                 illegal_instr
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_MDU_WAIT, S_WRITEBACK, S_TRAP
  } state_t;

  typedef enum logic [3:0] {
    C_ALU_R, C_ALU_I, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_JALR,
    C_LUI, C_AUIPC, C_MDU, C_ILLEGAL
  } class_t;

  state_t               state_reg;
  logic [CNT_WIDTH-1:0] instret_reg;
  class_t               cls;
  logic [2:0]           dec_imm_src;
  logic [1:0]           dec_alu_a_src;
  logic                 dec_alu_b_src;
  logic [3:0]           dec_alu_op;
  logic                 retire_now;
  logic                 mdu_done_gated;
  logic                 datapath_active;

  assign mdu_done_gated = (M_EXT != 0) && mdu_done;
  assign instret        = instret_reg;

  // Instruction class straight from the IR fields; anything unrecognised is illegal.
  always_comb begin
    cls = C_ILLEGAL;
    case (opcode)
      OP_REG: begin
        if (funct7 == 7'b0000000) begin
          cls = C_ALU_R;
        end else if (funct7 == 7'b0100000) begin
          if (funct3 == 3'b000 || funct3 == 3'b101) cls = C_ALU_R;
        end else if (funct7 == 7'b0000001 && M_EXT != 0) begin
          cls = C_MDU;
        end
      end
      OP_IMM: begin
        cls = C_ALU_I;
        if (funct3 == 3'b001 && funct7 != 7'b0000000) cls = C_ILLEGAL;
        if (funct3 == 3'b101 && funct7 != 7'b0000000 && funct7 != 7'b0100000) cls = C_ILLEGAL;
      end
      OP_LOAD:   cls = C_LOAD;
      OP_STORE:  cls = C_STORE;
      OP_BRANCH: cls = (funct3 == 3'b010 || funct3 == 3'b011) ? C_ILLEGAL : C_BRANCH;
      OP_JAL:    cls = C_JAL;
      OP_JALR:   cls = C_JALR;
      OP_LUI:    cls = C_LUI;
      OP_AUIPC:  cls = C_AUIPC;
      default:   cls = C_ILLEGAL;
    endcase
  end

  always_comb begin
    dec_imm_src   = 3'b000;
    dec_alu_a_src = 2'b00;
    dec_alu_b_src = 1'b0;
    dec_alu_op    = 4'b0000;
    case (cls)
      C_ALU_R, C_MDU: dec_alu_op = {funct7[5], funct3};
      C_ALU_I: begin
        dec_alu_b_src = 1'b1;
        dec_alu_op    = (funct3 == 3'b101) ? {funct7[5], funct3} : {1'b0, funct3};
      end
      C_LOAD, C_JALR: dec_alu_b_src = 1'b1;
      C_STORE: begin
        dec_imm_src   = 3'b001;
        dec_alu_b_src = 1'b1;
      end
      C_BRANCH: dec_imm_src = 3'b010;
      C_JAL: begin
        dec_imm_src   = 3'b100;
        dec_alu_a_src = 2'b01;
        dec_alu_b_src = 1'b1;
      end
      C_LUI: begin
        dec_imm_src   = 3'b011;
        dec_alu_a_src = 2'b10;
        dec_alu_b_src = 1'b1;
      end
      C_AUIPC: begin
        dec_imm_src   = 3'b011;
        dec_alu_a_src = 2'b01;
        dec_alu_b_src = 1'b1;
      end
      default: begin
        dec_imm_src   = 3'b000;
        dec_alu_a_src = 2'b00;
        dec_alu_b_src = 1'b0;
        dec_alu_op    = 4'b0000;
      end
    endcase
  end

  assign retire_now = (state_reg == S_EXECUTE && cls == C_BRANCH) ||
                      (state_reg == S_MEM && dm_ready && cls == C_STORE) ||
                      (state_reg == S_WRITEBACK);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= S_IDLE;
      instret_reg <= '0;
    end else begin
      if (retire_now) instret_reg <= instret_reg + CNT_WIDTH'(1);
      case (state_reg)
        S_IDLE:   state_reg <= S_FETCH;
        S_FETCH:  if (imem_ready) state_reg <= S_DECODE;
        S_DECODE: state_reg <= (cls == C_ILLEGAL) ? S_TRAP : S_EXECUTE;
        S_EXECUTE: begin
          case (cls)
            C_LOAD, C_STORE: state_reg <= S_MEM;
            C_BRANCH:        state_reg <= S_FETCH;
            C_MDU:           state_reg <= S_MDU_WAIT;
            default:         state_reg <= S_WRITEBACK;
          endcase
        end
        S_MEM: begin
          if (dm_ready) state_reg <= (cls == C_STORE) ? S_FETCH : S_WRITEBACK;
        end
        S_MDU_WAIT:  if (mdu_done_gated) state_reg <= S_WRITEBACK;
        S_WRITEBACK: state_reg <= S_FETCH;
        S_TRAP:      state_reg <= S_TRAP;
        default:     state_reg <= S_IDLE;
      endcase
    end
  end

  // Outputs are decoded from the registered state so handshakes are answered in the same cycle.
  assign datapath_active = (state_reg == S_EXECUTE) || (state_reg == S_MEM) ||
                           (state_reg == S_MDU_WAIT) || (state_reg == S_WRITEBACK);

  always_comb begin
    imem_req      = 1'b0;
    ir_write      = 1'b0;
    ru_write      = 1'b0;
    alu_op        = 4'b0000;
    imm_src       = 3'b000;
    alu_a_src     = 2'b00;
    alu_b_src     = 1'b0;
    dm_req        = 1'b0;
    dm_write      = 1'b0;
    dm_ctrl       = 3'b000;
    br_op         = 5'b00000;
    ru_data_src   = 2'b00;
    pc_write      = 1'b0;
    mdu_start     = 1'b0;
    retire        = 1'b0;
    illegal_instr = 1'b0;

    if (state_reg == S_DECODE || datapath_active) begin
      imm_src   = dec_imm_src;
      alu_a_src = dec_alu_a_src;
      alu_b_src = dec_alu_b_src;
    end
    if (datapath_active) alu_op = dec_alu_op;

    case (state_reg)
      S_FETCH: begin
        imem_req = 1'b1;
        ir_write = imem_ready;
      end
      S_EXECUTE: mdu_start = (cls == C_MDU);
      S_MEM: begin
        dm_req   = 1'b1;
        dm_write = (cls == C_STORE);
        dm_ctrl  = funct3;
      end
      S_WRITEBACK: begin
        ru_write = 1'b1;
        case (cls)
          C_LOAD:         ru_data_src = 2'b01;
          C_JAL, C_JALR:  ru_data_src = 2'b10;
          C_MDU:          ru_data_src = 2'b11;
          default:        ru_data_src = 2'b00;
        endcase
      end
      S_TRAP: illegal_instr = 1'b1;
      default: begin
        imem_req = 1'b0;
      end
    endcase

    if (retire_now) begin
      retire   = 1'b1;
      pc_write = 1'b1;
      if (cls == C_JAL || cls == C_JALR) br_op = 5'b10000;
      else if (cls == C_BRANCH)          br_op = {2'b01, funct3};
    end
  end

endmodule
